fifo2: RTL and testbench

//   Single-clock synchronous FIFO buffering 8-bit data between a producer and a

---
 rtl/fifo2_if.sv | 31 +++
 rtl/fifo2.sv | 75 +++++++
 tb/tb_fifo2.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo2_if.sv
// ============================================================================
// Module      : fifo2_if
// Description : Producer/consumer handshake bundle for the fifo2 buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_in;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic [CNT_WIDTH-1:0]  fifo_counter;

  modport master (
    output wr_en, rd_en, buf_in,
    input  buf_out, buf_empty, buf_full, fifo_counter
  );

  modport slave (
    input  wr_en, rd_en, buf_in,
    output buf_out, buf_empty, buf_full, fifo_counter
  );
endinterface

`default_nettype wire

// File: rtl/fifo2.sv
// ============================================================================
// Module      : fifo2
// Description : Single-clock synchronous FIFO with occupancy count and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  wire logic  clk,
  input  wire logic  rst,
  fifo2_if.slave     bus
);

  localparam logic [CNT_WIDTH-1:0]  FULL_COUNT = CNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags decode the live count so they move in the same cycle as the count.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign wr_ok = bus.wr_en & ~full;
  assign rd_ok = bus.rd_en & ~empty;

  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.fifo_counter = count;
  assign bus.buf_out      = out_q;

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.buf_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        out_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo2.sv
// ============================================================================
// Module      : tb_fifo2
// Description : Directed self-checking bench for fifo2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fifo2_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

  fifo2 #(
    .DATA_WIDTH(8),
    .DEPTH(64),
    .ADDR_WIDTH(6),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b0;
    bus.buf_in = d;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic pop();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fill_vals [4];
    logic [7:0] alt_vals [3];
    logic [7:0] exp_b;

    total = 0;
    bad   = 0;
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    alt_vals  = '{8'hAA, 8'hBB, 8'hCC};
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.buf_in = 8'h00;
    rst = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_count", 32'(bus.fifo_counter), 32'd0);
    check("rst_empty", 32'(bus.buf_empty), 32'd1);
    check("rst_full", 32'(bus.buf_full), 32'd0);
    check("rst_out", 32'(bus.buf_out), 32'h00);
    rst = 1'b1;
    tick();
    check("rel_empty", 32'(bus.buf_empty), 32'd1);
    check("rel_full", 32'(bus.buf_full), 32'd0);

    // Fill then drain
    for (int i = 0; i < 4; i++) push(fill_vals[i]);
    check("fill_count", 32'(bus.fifo_counter), 32'd4);
    check("fill_empty", 32'(bus.buf_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      pop();
      check("drain_data", 32'(bus.buf_out), 32'(fill_vals[i]));
    end
    check("drain_count", 32'(bus.fifo_counter), 32'd0);
    check("drain_empty", 32'(bus.buf_empty), 32'd1);

    // Alternating write/read
    for (int i = 0; i < 3; i++) begin
      push(alt_vals[i]);
      check("alt_count1", 32'(bus.fifo_counter), 32'd1);
      pop();
      check("alt_data", 32'(bus.buf_out), 32'(alt_vals[i]));
      check("alt_count0", 32'(bus.fifo_counter), 32'd0);
    end

    // Fill to full, overflow attempt, drain
    for (int i = 0; i < 64; i++) push(8'(i));
    check("full_flag", 32'(bus.buf_full), 32'd1);
    check("full_count", 32'(bus.fifo_counter), 32'd64);
    push(8'hFF);
    check("ovf_count", 32'(bus.fifo_counter), 32'd64);
    check("ovf_full", 32'(bus.buf_full), 32'd1);
    for (int i = 0; i < 64; i++) begin
      pop();
      check("full_drain", 32'(bus.buf_out), 32'(i));
    end
    check("full_drained", 32'(bus.fifo_counter), 32'd0);

    // Underflow: output holds 3F
    for (int i = 0; i < 3; i++) begin
      pop();
      check("udf_out", 32'(bus.buf_out), 32'h3F);
      check("udf_count", 32'(bus.fifo_counter), 32'd0);
    end

    // Pointers now at 7 (4+3+64 mod 64); walk both to 61
    for (int i = 0; i < 54; i++) begin
      push(8'h5C);
      pop();
    end
    push(8'hD0);
    push(8'hD1);
    check("wrap_pre", 32'(bus.fifo_counter), 32'd2);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.buf_in = 8'hE0 + 8'(i);
      tick();
      exp_b = (i == 0) ? 8'hD0 : (i == 1) ? 8'hD1 : 8'hE0 + 8'(i - 2);
      check("wrap_data", 32'(bus.buf_out), 32'(exp_b));
      check("wrap_count", 32'(bus.fifo_counter), 32'd2);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    pop();
    check("wrap_tail0", 32'(bus.buf_out), 32'hE8);
    pop();
    check("wrap_tail1", 32'(bus.buf_out), 32'hE9);
    check("wrap_empty", 32'(bus.buf_empty), 32'd1);

    // Both while empty: write only
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b1;
    bus.buf_in = 8'h5A;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("both_empty_cnt", 32'(bus.fifo_counter), 32'd1);
    check("both_empty_out", 32'(bus.buf_out), 32'hE9);

    // Both while full: read only
    for (int i = 0; i < 63; i++) push(8'(i));
    check("both_full_pre", 32'(bus.buf_full), 32'd1);
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b1;
    bus.buf_in = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("both_full_cnt", 32'(bus.fifo_counter), 32'd63);
    check("both_full_out", 32'(bus.buf_out), 32'h5A);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 32'(bus.fifo_counter), 32'd0);
    check("arst_empty", 32'(bus.buf_empty), 32'd1);
    check("arst_full", 32'(bus.buf_full), 32'd0);
    check("arst_out", 32'(bus.buf_out), 32'h00);
    #1;
    rst = 1'b1;
    tick();
    check("arst_hold", 32'(bus.buf_empty), 32'd1);
    push(8'h77);
    pop();
    check("post_rst_data", 32'(bus.buf_out), 32'h77);
    check("post_rst_cnt", 32'(bus.fifo_counter), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
